alu_issue_wb: RTL and testbench

//  Sequencer between AXIS CPU decode and the ALU. Accepts one arith/jump op per valid/ready handshake,

---
 rtl/alu_issue_wb.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_wb.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_wb
// Purpose  : Issues one arith/jump op at a time to the ALU, owns A and X,
//            writes results back to A or resolves conditional jumps.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_wb #(
    parameter int OFF_W    = 8,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_vld,
    output logic             op_rdy,
    input  logic [3:0]       op_sel,
    input  logic             op_bimm,
    input  logic [31:0]      op_imm,
    input  logic             op_jmp,
    input  logic [1:0]       op_jcond,
    input  logic [OFF_W-1:0] op_jt,
    input  logic [OFF_W-1:0] op_jf,
    input  logic             a_wr_en,
    input  logic [31:0]      a_wr_data,
    input  logic             x_wr_en,
    input  logic [31:0]      x_wr_data,
    output logic [31:0]      regA,
    output logic [31:0]      regX,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [3:0]       alu_sel,
    output logic             alu_en,
    input  logic [31:0]      alu_out,
    input  logic             alu_eq,
    input  logic             alu_gt,
    input  logic             alu_ge,
    input  logic             alu_set,
    input  logic             alu_vld,
    output logic             alu_ack,
    output logic             br_vld,
    output logic             br_taken,
    output logic [OFF_W-1:0] br_off,
    output logic             err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    localparam int                c_WD_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(MAX_WAIT - 1);

    logic [1:0]       r_state;
    logic [31:0]      r_reg_a;
    logic [31:0]      r_reg_x;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [3:0]       r_alu_sel;
    logic             r_alu_en;
    logic             r_jmp;
    logic [1:0]       r_jcond;
    logic [OFF_W-1:0] r_jt;
    logic [OFF_W-1:0] r_jf;
    logic             r_br_vld;
    logic             r_br_taken;
    logic [OFF_W-1:0] r_br_off;
    logic             r_err;
    logic [c_WD_W-1:0] r_wdog;

    logic        w_fire;
    logic [31:0] w_b;
    logic        w_bad_sel;
    logic        w_div0;
    logic        w_taken;

    assign op_rdy    = (r_state == c_IDLE) && !rst;
    assign alu_ack   = (r_state == c_WAIT) && alu_vld && !rst;
    assign w_fire    = op_vld && op_rdy;
    assign w_b       = op_bimm ? op_imm : r_reg_x;
    assign w_bad_sel = !op_jmp && (op_sel > 4'd10);
    assign w_div0    = !op_jmp && ((op_sel == 4'd9) || (op_sel == 4'd10)) && (w_b == 32'd0);

    always_comb begin
        w_taken = 1'b0;
        case (r_jcond)
            2'd0:    w_taken = alu_eq;
            2'd1:    w_taken = alu_gt;
            2'd2:    w_taken = alu_ge;
            default: w_taken = alu_set;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_reg_a    <= '0;
            r_reg_x    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_alu_en   <= 1'b0;
            r_jmp      <= 1'b0;
            r_jcond    <= '0;
            r_jt       <= '0;
            r_jf       <= '0;
            r_br_vld   <= 1'b0;
            r_br_taken <= 1'b0;
            r_br_off   <= '0;
            r_err      <= 1'b0;
            r_wdog     <= '0;
        end else begin
            r_alu_en <= 1'b0;
            r_br_vld <= 1'b0;
            r_err    <= 1'b0;
            // External loads sit first so a same-cycle writeback overrides them.
            if (a_wr_en) r_reg_a <= a_wr_data;
            if (x_wr_en) r_reg_x <= x_wr_data;
            case (r_state)
                c_IDLE: begin
                    if (w_fire) begin
                        r_alu_a   <= r_reg_a;
                        r_alu_b   <= w_b;
                        r_alu_sel <= op_jmp ? 4'd0 : op_sel;
                        r_jmp     <= op_jmp;
                        r_jcond   <= op_jcond;
                        r_jt      <= op_jt;
                        r_jf      <= op_jf;
                        if (w_bad_sel) begin
                            r_err <= 1'b1;
                        end else if (w_div0) begin
                            r_reg_a <= '0;
                            r_err   <= 1'b1;
                        end else begin
                            r_alu_en <= 1'b1;
                            r_state  <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (alu_vld) begin
                        if (r_jmp) begin
                            r_br_vld   <= 1'b1;
                            r_br_taken <= w_taken;
                            r_br_off   <= w_taken ? r_jt : r_jf;
                        end else begin
                            r_reg_a <= alu_out;
                        end
                        r_state <= c_IDLE;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign regA     = r_reg_a;
    assign regX     = r_reg_x;
    assign alu_A    = r_alu_a;
    assign alu_B    = r_alu_b;
    assign alu_sel  = r_alu_sel;
    assign alu_en   = r_alu_en;
    assign br_vld   = r_br_vld;
    assign br_taken = r_br_taken;
    assign br_off   = r_br_off;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_wb
// Purpose  : Scoreboard bench for alu_issue_wb with a behavioural ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_wb;

    localparam int OFF_W    = 8;
    localparam int MAX_WAIT = 64;
    localparam int c_TMO    = 200;

    logic clk = 1'b0;
    logic rst;
    logic op_vld, op_rdy, op_bimm, op_jmp;
    logic [3:0] op_sel;
    logic [31:0] op_imm;
    logic [1:0] op_jcond;
    logic [OFF_W-1:0] op_jt, op_jf;
    logic a_wr_en, x_wr_en;
    logic [31:0] a_wr_data, x_wr_data;
    logic [31:0] regA, regX, alu_A, alu_B, alu_out;
    logic [3:0] alu_sel;
    logic alu_en, alu_eq, alu_gt, alu_ge, alu_set, alu_vld, alu_ack;
    logic br_vld, br_taken, err;
    logic [OFF_W-1:0] br_off;

    always #5 clk = ~clk;

    alu_issue_wb #(.OFF_W(OFF_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .op_vld(op_vld), .op_rdy(op_rdy), .op_sel(op_sel), .op_bimm(op_bimm),
        .op_imm(op_imm), .op_jmp(op_jmp), .op_jcond(op_jcond), .op_jt(op_jt), .op_jf(op_jf),
        .a_wr_en(a_wr_en), .a_wr_data(a_wr_data), .x_wr_en(x_wr_en), .x_wr_data(x_wr_data),
        .regA(regA), .regX(regX), .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel),
        .alu_en(alu_en), .alu_out(alu_out), .alu_eq(alu_eq), .alu_gt(alu_gt),
        .alu_ge(alu_ge), .alu_set(alu_set), .alu_vld(alu_vld), .alu_ack(alu_ack),
        .br_vld(br_vld), .br_taken(br_taken), .br_off(br_off), .err(err)
    );

    // Behavioural ALU: 1 cycle for sel 0-7, 5 for MUL, 33 for DIV/MOD.
    logic m_dead;
    int   m_cnt;

    function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return b;
            4'd8: return a * b;
            4'd9: return (b == 0) ? 32'd0 : a / b;
            4'd10: return (b == 0) ? 32'd0 : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int alu_lat(input logic [3:0] s);
        if (s == 4'd8) return 5;
        if (s == 4'd9 || s == 4'd10) return 33;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            alu_vld <= 1'b0;
            m_cnt   <= 0;
        end else begin
            if (alu_ack) alu_vld <= 1'b0;
            if (alu_en && !m_dead) begin
                if (alu_lat(alu_sel) == 1) begin
                    alu_vld <= 1'b1;
                    alu_out <= alu_fn(alu_sel, alu_A, alu_B);
                    alu_eq  <= (alu_A == alu_B);
                    alu_gt  <= (alu_A > alu_B);
                    alu_ge  <= (alu_A >= alu_B);
                    alu_set <= ((alu_A & alu_B) != 0);
                end else begin
                    m_cnt <= alu_lat(alu_sel) - 1;
                end
            end else if (m_cnt != 0) begin
                if (m_cnt == 1) begin
                    alu_vld <= 1'b1;
                    alu_out <= alu_fn(alu_sel, alu_A, alu_B);
                    alu_eq  <= (alu_A == alu_B);
                    alu_gt  <= (alu_A > alu_B);
                    alu_ge  <= (alu_A >= alu_B);
                    alu_set <= ((alu_A & alu_B) != 0);
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [31:0]      a;
        logic             brv;
        logic             taken;
        logic [OFF_W-1:0] off;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    logic [31:0]      obs_a;
    logic             obs_brv, obs_taken, obs_err, obs_stable;
    logic [OFF_W-1:0] obs_off;
    int               obs_cyc, obs_en, obs_ack;

    task automatic load_regs(input logic [31:0] a, input logic [31:0] x);
        a_wr_en = 1'b1; a_wr_data = a; x_wr_en = 1'b1; x_wr_data = x;
        @(negedge clk);
        a_wr_en = 1'b0; x_wr_en = 1'b0;
    endtask

    // Offers one op, waits for the FSM to return to IDLE and snapshots outputs.
    task automatic run_op(input logic [3:0] sel, input logic bimm, input logic [31:0] imm,
                          input logic jmp, input logic [1:0] jc, input logic [OFF_W-1:0] jt,
                          input logic [OFF_W-1:0] jf, input logic wr_at_ack);
        logic [31:0] a0, b0;
        logic [3:0]  s0;
        op_vld = 1'b1; op_sel = sel; op_bimm = bimm; op_imm = imm;
        op_jmp = jmp; op_jcond = jc; op_jt = jt; op_jf = jf;
        for (int k = 0; k < c_TMO && !op_rdy; k++) @(negedge clk);
        if (!op_rdy) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: op_rdy=%b required 1", op_rdy);
            op_vld = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        op_vld = 1'b0;
        a0 = alu_A; b0 = alu_B; s0 = alu_sel;
        obs_cyc = 0; obs_en = 0; obs_ack = 0; obs_stable = 1'b1;
        while (!op_rdy && obs_cyc < c_TMO) begin
            a_wr_en = 1'b0;
            if (alu_en) obs_en++;
            if (alu_ack) begin
                obs_ack++;
                if (wr_at_ack) begin a_wr_en = 1'b1; a_wr_data = 32'h0000_FFFF; end
            end
            if (alu_A !== a0 || alu_B !== b0 || alu_sel !== s0) obs_stable = 1'b0;
            @(negedge clk);
            obs_cyc++;
        end
        a_wr_en = 1'b0;
        if (!op_rdy) begin
            checks++; failures++;
            $display("FAIL completion_timeout: op_rdy=%b required 1", op_rdy);
        end
        obs_a = regA; obs_brv = br_vld; obs_taken = br_taken; obs_off = br_off; obs_err = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (op_rdy !== 1'b0) begin failures++; $display("FAIL reset_op_rdy got=%b exp=0", op_rdy); end
        checks++; if ({regA, regX, alu_A, alu_B} !== 128'd0) begin failures++; $display("FAIL reset_regs got=%h %h %h %h exp=0", regA, regX, alu_A, alu_B); end
        checks++; if ({alu_sel, alu_en, alu_ack, br_vld, br_taken, br_off, err} !== '0) begin failures++;
            $display("FAIL reset_ctrl got sel=%h en=%b ack=%b brv=%b brt=%b off=%h err=%b exp=0", alu_sel, alu_en, alu_ack, br_vld, br_taken, br_off, err); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (op_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_rdy got=%b exp=1", op_rdy); end
    endtask

    task automatic test_add();
        load_regs(32'd5, 32'd7);
        sb.push_back('{a: 32'd12, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 2});
        run_op(4'd0, 1'b0, 32'd0, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a) begin failures++; $display("FAIL add_regA got=%h exp=%h", obs_a, e.a); end
        checks++; if (obs_cyc !== e.cyc) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", obs_cyc, e.cyc); end
        checks++; if (obs_en !== 1 || obs_ack !== 1) begin failures++; $display("FAIL add_en_ack got en=%0d ack=%0d exp 1 1", obs_en, obs_ack); end
        checks++; if (obs_err !== e.err || obs_brv !== e.brv) begin failures++; $display("FAIL add_flags got err=%b brv=%b exp 0 0", obs_err, obs_brv); end
    endtask

    task automatic test_back_to_back();
        load_regs(32'd6, 32'd7);
        sb.push_back('{a: 32'd42, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 6});
        sb.push_back('{a: 32'd40, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 2});
        run_op(4'd8, 1'b1, 32'd7, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a) begin failures++; $display("FAIL mul_regA got=%h exp=%h", obs_a, e.a); end
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL mul_operand_stable got=%b exp=1", obs_stable); end
        checks++; if (obs_cyc !== e.cyc) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", obs_cyc, e.cyc); end
        run_op(4'd1, 1'b1, 32'd2, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a) begin failures++; $display("FAIL sub_regA got=%h exp=%h", obs_a, e.a); end
        checks++; if (obs_cyc !== e.cyc) begin failures++; $display("FAIL sub_latency got=%0d exp=%0d", obs_cyc, e.cyc); end
    endtask

    task automatic test_div();
        load_regs(32'd100, 32'd0);
        sb.push_back('{a: 32'd14, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 34});
        run_op(4'd9, 1'b1, 32'd7, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a || obs_cyc !== e.cyc) begin failures++; $display("FAIL div_regA got=%h cyc=%0d exp=%h cyc=%0d", obs_a, obs_cyc, e.a, e.cyc); end
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL div_operand_stable got=%b exp=1", obs_stable); end
        load_regs(32'd100, 32'd0);
        sb.push_back('{a: 32'd2, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 34});
        run_op(4'd10, 1'b1, 32'd7, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a) begin failures++; $display("FAIL mod_regA got=%h exp=%h", obs_a, e.a); end
        // Divide by X=0: immediate error, A cleared, nothing issued.
        sb.push_back('{a: 32'd0, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b1, cyc: 0});
        run_op(4'd9, 1'b0, 32'd0, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a || obs_err !== e.err) begin failures++; $display("FAIL div0 got regA=%h err=%b exp regA=%h err=%b", obs_a, obs_err, e.a, e.err); end
        checks++; if (obs_en !== 0 || obs_cyc !== e.cyc) begin failures++; $display("FAIL div0_no_issue got en=%0d cyc=%0d exp 0 0", obs_en, obs_cyc); end
        load_regs(32'h55, 32'd0);
        sb.push_back('{a: 32'h55, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b1, cyc: 0});
        run_op(4'd11, 1'b1, 32'd3, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a || obs_err !== e.err || obs_en !== 0) begin failures++;
            $display("FAIL bad_sel got regA=%h err=%b en=%0d exp regA=%h err=1 en=0", obs_a, obs_err, obs_en, e.a); end
    endtask

    task automatic test_jump();
        load_regs(32'd3, 32'd3);
        sb.push_back('{a: 32'd3, brv: 1'b1, taken: 1'b1, off: 8'd4, err: 1'b0, cyc: 2});
        sb.push_back('{a: 32'd3, brv: 1'b1, taken: 1'b0, off: 8'd9, err: 1'b0, cyc: 2});
        sb.push_back('{a: 32'd3, brv: 1'b1, taken: 1'b1, off: 8'd4, err: 1'b0, cyc: 2});
        // Jumps carry junk op_sel values; they must still run as one-cycle ADDs.
        run_op(4'd9, 1'b0, 32'd0, 1'b1, 2'd0, 8'd4, 8'd9, 1'b0);
        e = sb.pop_front();
        checks++; if ({obs_brv, obs_taken, obs_off} !== {e.brv, e.taken, e.off} || obs_a !== e.a) begin failures++;
            $display("FAIL jmp_eq got brv=%b t=%b off=%0d A=%h exp %b %b %0d %h", obs_brv, obs_taken, obs_off, obs_a, e.brv, e.taken, e.off, e.a); end
        checks++; if (obs_cyc !== e.cyc || obs_ack !== 1) begin failures++; $display("FAIL jmp_latency got cyc=%0d ack=%0d exp %0d 1", obs_cyc, obs_ack, e.cyc); end
        run_op(4'd15, 1'b0, 32'd0, 1'b1, 2'd1, 8'd4, 8'd9, 1'b0);
        e = sb.pop_front();
        checks++; if ({obs_brv, obs_taken, obs_off, obs_err} !== {e.brv, e.taken, e.off, e.err} || obs_a !== e.a) begin failures++;
            $display("FAIL jmp_gt got brv=%b t=%b off=%0d err=%b A=%h exp %b %b %0d 0 %h", obs_brv, obs_taken, obs_off, obs_err, obs_a, e.brv, e.taken, e.off, e.a); end
        run_op(4'd0, 1'b0, 32'd0, 1'b1, 2'd2, 8'd4, 8'd9, 1'b0);
        e = sb.pop_front();
        checks++; if ({obs_brv, obs_taken, obs_off} !== {e.brv, e.taken, e.off}) begin failures++;
            $display("FAIL jmp_ge got brv=%b t=%b off=%0d exp %b %b %0d", obs_brv, obs_taken, obs_off, e.brv, e.taken, e.off); end
        load_regs(32'd1, 32'd3);
        sb.push_back('{a: 32'd1, brv: 1'b1, taken: 1'b0, off: 8'd9, err: 1'b0, cyc: 2});
        run_op(4'd0, 1'b1, 32'd2, 1'b1, 2'd3, 8'd4, 8'd9, 1'b0);
        e = sb.pop_front();
        checks++; if ({obs_brv, obs_taken, obs_off} !== {e.brv, e.taken, e.off} || obs_a !== e.a) begin failures++;
            $display("FAIL jmp_set got brv=%b t=%b off=%0d A=%h exp %b %b %0d %h", obs_brv, obs_taken, obs_off, obs_a, e.brv, e.taken, e.off, e.a); end
    endtask

    task automatic test_watchdog();
        m_dead = 1'b1;
        load_regs(32'h1234, 32'd0);
        sb.push_back('{a: 32'h1234, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b1, cyc: MAX_WAIT + 1});
        run_op(4'd0, 1'b1, 32'd1, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        m_dead = 1'b0;
        checks++; if (obs_err !== e.err || obs_cyc !== e.cyc) begin failures++; $display("FAIL watchdog got err=%b cyc=%0d exp err=1 cyc=%0d", obs_err, obs_cyc, e.cyc); end
        checks++; if (obs_a !== e.a || obs_ack !== 0) begin failures++; $display("FAIL watchdog_no_wb got A=%h ack=%0d exp %h 0", obs_a, obs_ack, e.a); end
    endtask

    task automatic test_rst_mid_op();
        logic seen;
        load_regs(32'd100, 32'd0);
        op_vld = 1'b1; op_sel = 4'd9; op_bimm = 1'b1; op_imm = 32'd7; op_jmp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op_vld = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        checks++; if (alu_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", alu_ack); end
        @(negedge clk);
        checks++; if (regA !== 32'd0 || br_vld !== 1'b0 || alu_en !== 1'b0) begin failures++;
            $display("FAIL rst_mid_op got A=%h brv=%b en=%b exp 0 0 0", regA, br_vld, alu_en); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (alu_ack || br_vld || alu_en) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || regA !== 32'd0 || op_rdy !== 1'b1) begin failures++;
            $display("FAIL rst_aftermath got activity=%b A=%h rdy=%b exp 0 0 1", seen, regA, op_rdy); end
    endtask

    task automatic test_ext_write();
        load_regs(32'h10, 32'd0);
        sb.push_back('{a: 32'h30, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 2});
        run_op(4'd0, 1'b1, 32'h20, 1'b0, 2'd0, '0, '0, 1'b1);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a) begin failures++; $display("FAIL wb_beats_ext got=%h exp=%h", obs_a, e.a); end
        a_wr_en = 1'b1; a_wr_data = 32'h0000_FFFF;
        @(negedge clk);
        a_wr_en = 1'b0;
        checks++; if (regA !== 32'h0000_FFFF) begin failures++; $display("FAIL ext_load_idle got=%h exp=0000ffff", regA); end
        load_regs(32'hFFFF_FFFF, 32'd0);
        sb.push_back('{a: 32'd0, brv: 1'b0, taken: 1'b0, off: '0, err: 1'b0, cyc: 2});
        run_op(4'd0, 1'b1, 32'd1, 1'b0, 2'd0, '0, '0, 1'b0);
        e = sb.pop_front();
        checks++; if (obs_a !== e.a) begin failures++; $display("FAIL add_wrap got=%h exp=%h", obs_a, e.a); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; m_dead = 1'b0;
        op_vld = 1'b0; op_sel = '0; op_bimm = 1'b0; op_imm = '0; op_jmp = 1'b0;
        op_jcond = '0; op_jt = '0; op_jf = '0;
        a_wr_en = 1'b0; a_wr_data = '0; x_wr_en = 1'b0; x_wr_data = '0;
        alu_out = '0; alu_eq = 1'b0; alu_gt = 1'b0; alu_ge = 1'b0; alu_set = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_div();
        test_jump();
        test_watchdog();
        test_rst_mid_op();
        test_ext_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
